// File: rtl/channel_arbiter_if.sv
// Channel arbiter bus: per-channel packet/metadata inputs and the merged outputs.
// Modport slave is the arbiter itself; modport master is the surrounding sources and sinks.

package channel_arbiter_pkg;
   typedef struct packed {
      logic [15:0] length;
      logic [15:0] flow_id;
      logic [31:0] tstamp;
   } metadata_t;
endpackage

interface channel_arbiter_if #(
   parameter int unsigned NUM_CH = 4
) ();
   // per-channel packet inputs
   logic [511:0] in_pkt_data  [NUM_CH];
   logic         in_pkt_valid [NUM_CH];
   logic         in_pkt_sop   [NUM_CH];
   logic         in_pkt_eop   [NUM_CH];
   logic [5:0]   in_pkt_empty [NUM_CH];
   logic         in_pkt_ready [NUM_CH];

   // per-channel metadata inputs
   channel_arbiter_pkg::metadata_t in_meta_data [NUM_CH];
   logic                           in_meta_valid [NUM_CH];
   logic                           in_meta_ready [NUM_CH];

   // merged packet output
   logic [511:0] out_pkt_data;
   logic         out_pkt_valid;
   logic         out_pkt_sop;
   logic         out_pkt_eop;
   logic [5:0]   out_pkt_empty;
   logic [1:0]   out_pkt_channel;
   logic         out_pkt_ready;
   logic         out_pkt_almost_full;

   // merged metadata output
   channel_arbiter_pkg::metadata_t out_meta_data;
   logic                           out_meta_valid;
   logic [1:0]                     out_meta_channel;
   logic                           out_meta_ready;
   logic                           out_meta_almost_full;

   logic proto_err;

   modport slave (
      input  in_pkt_data, in_pkt_valid, in_pkt_sop, in_pkt_eop, in_pkt_empty,
      output in_pkt_ready,
      input  in_meta_data, in_meta_valid,
      output in_meta_ready,
      output out_pkt_data, out_pkt_valid, out_pkt_sop, out_pkt_eop, out_pkt_empty,
      output out_pkt_channel,
      input  out_pkt_ready, out_pkt_almost_full,
      output out_meta_data, out_meta_valid, out_meta_channel,
      input  out_meta_ready, out_meta_almost_full,
      output proto_err
   );

   modport master (
      output in_pkt_data, in_pkt_valid, in_pkt_sop, in_pkt_eop, in_pkt_empty,
      input  in_pkt_ready,
      output in_meta_data, in_meta_valid,
      input  in_meta_ready,
      input  out_pkt_data, out_pkt_valid, out_pkt_sop, out_pkt_eop, out_pkt_empty,
      input  out_pkt_channel,
      output out_pkt_ready, out_pkt_almost_full,
      input  out_meta_data, out_meta_valid, out_meta_channel,
      output out_meta_ready, out_meta_almost_full,
      input  proto_err
   );
endinterface

// File: rtl/channel_arbiter.sv
// Round-robin packet arbiter: picks an eligible channel, forwards its metadata word,
// then passes its packet through until eop. Optional sop/eop protocol checker is
// enabled by defining CHANNEL_ARBITER_CHECK_EN; otherwise proto_err is tied low.

module channel_arbiter #(
   parameter int unsigned NUM_CH = 4
) (
   input logic              clk,
   input logic              rst_n,
   channel_arbiter_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StMeta, StPkt} state_e;

   state_e      state_q;
   logic [1:0]  sel_q;
   logic [1:0]  rr_ptr_q;

   logic [NUM_CH-1:0] eligible;
   logic              any_elig;
   logic [1:0]        pick;
   logic              meta_hs;
   logic              pkt_hs;

   function automatic logic [1:0] wrap_add(logic [1:0] base, int unsigned off);
      return 2'((32'(base) + off) % NUM_CH);
   endfunction

   // a channel may start only when its metadata and the first beat are both present
   always_comb begin
      eligible = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         eligible[c] = bus.in_meta_valid[c] & bus.in_pkt_valid[c] & bus.in_pkt_sop[c];
      end
   end

   // first eligible channel searching upward from rr_ptr
   always_comb begin
      any_elig = 1'b0;
      pick     = rr_ptr_q;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (!any_elig && eligible[wrap_add(rr_ptr_q, i)]) begin
            any_elig = 1'b1;
            pick     = wrap_add(rr_ptr_q, i);
         end
      end
   end

   assign meta_hs = (state_q == StMeta) && bus.in_meta_valid[sel_q] && bus.out_meta_ready;
   assign pkt_hs  = (state_q == StPkt) && bus.in_pkt_valid[sel_q] && bus.out_pkt_ready;

   // combinational pass-through from the selected channel, gated by state
   always_comb begin
      bus.out_meta_valid = (state_q == StMeta) && bus.in_meta_valid[sel_q];
      bus.out_meta_data  = bus.in_meta_data[sel_q];
      bus.out_pkt_valid  = (state_q == StPkt) && bus.in_pkt_valid[sel_q];
      bus.out_pkt_data   = bus.in_pkt_data[sel_q];
      bus.out_pkt_sop    = bus.in_pkt_sop[sel_q];
      bus.out_pkt_eop    = bus.in_pkt_eop[sel_q];
      bus.out_pkt_empty  = bus.in_pkt_empty[sel_q];
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         bus.in_meta_ready[c] = (state_q == StMeta) && (2'(c) == sel_q) && bus.out_meta_ready;
         bus.in_pkt_ready[c]  = (state_q == StPkt) && (2'(c) == sel_q) && bus.out_pkt_ready;
      end
   end

   assign bus.out_pkt_channel  = sel_q;
   assign bus.out_meta_channel = sel_q;

   // arbitration FSM; almost-full only gates a new grant, never an active packet
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         sel_q    <= '0;
         rr_ptr_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (any_elig && !bus.out_pkt_almost_full && !bus.out_meta_almost_full) begin
                  sel_q    <= pick;
                  rr_ptr_q <= wrap_add(pick, 1);
                  state_q  <= StMeta;
               end
            end
            StMeta: begin
               if (meta_hs) state_q <= StPkt;
            end
            StPkt: begin
               if (pkt_hs && bus.in_pkt_eop[sel_q]) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef CHANNEL_ARBITER_CHECK_EN
   logic first_beat_q;
   logic proto_err_q;

   // sticky error: sop must be set on the first accepted beat and on no other
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_beat_q <= 1'b0;
         proto_err_q  <= 1'b0;
      end else begin
         if (meta_hs) begin
            first_beat_q <= 1'b1;
         end else if (pkt_hs) begin
            first_beat_q <= 1'b0;
         end
         if (pkt_hs && (bus.in_pkt_sop[sel_q] != first_beat_q)) proto_err_q <= 1'b1;
      end
   end

   assign bus.proto_err = proto_err_q;
`else
   assign bus.proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_channel_arbiter.sv
// Self-checking bench for channel_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.

module tb_channel_arbiter;
   import channel_arbiter_pkg::*;

   localparam int unsigned NCH = 4;

   typedef struct {
      logic [511:0] data;
      logic         sop;
      logic         eop;
      logic [5:0]   empty;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   channel_arbiter_if #(.NUM_CH(NCH)) bus ();
   channel_arbiter #(.NUM_CH(NCH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   // source contents per channel
   beat_t     bq [NCH][$];
   metadata_t mq [NCH][$];

   // values presented this cycle
   logic drv_mv [NCH];
   logic drv_pv [NCH];
   logic drv_sop [NCH];

   // stimulus knobs
   int pr_mode = 0;   // 0 always ready, 1 random, 2 alternate by cycle
   int mr_mode = 0;   // 0 always ready, 1 random
   bit gaps = 0;
   bit paf_set = 0;
   bit rand_af = 0;

   // reference model: who owns the output and which phase it is in
   int m_phase = 0;   // 0 waiting for a grant, 1 metadata owed, 2 packet beats
   int m_sel = 0;
   int m_rr = 0;
   bit m_first = 0;
   bit m_err = 0;

   int cyc = 0;
   int grants[$];
   int gcycs[$];
   int beat_cycs[$];
   int meta_cyc = -1;
   int beats_out = 0;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(string tag, logic [511:0] got, logic [511:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic zero_inputs();
      for (int c = 0; c < NCH; c++) begin
         drv_mv[c] = 1'b0; drv_pv[c] = 1'b0; drv_sop[c] = 1'b0;
         bus.in_meta_valid[c] = 1'b0;
         bus.in_meta_data[c]  = '0;
         bus.in_pkt_valid[c]  = 1'b0;
         bus.in_pkt_data[c]   = '0;
         bus.in_pkt_sop[c]    = 1'b0;
         bus.in_pkt_eop[c]    = 1'b0;
         bus.in_pkt_empty[c]  = '0;
      end
      bus.out_pkt_ready = 1'b1;
      bus.out_meta_ready = 1'b1;
      bus.out_pkt_almost_full = 1'b0;
      bus.out_meta_almost_full = 1'b0;
   endtask

   task automatic clear_logs();
      grants.delete(); gcycs.delete(); beat_cycs.delete();
      meta_cyc = -1; beats_out = 0;
   endtask

   task automatic add_pkt(int ch, int nbeats, int bad_sop_beat = -1);
      metadata_t m;
      m.length = 16'(nbeats); m.flow_id = 16'(ch); m.tstamp = $urandom;
      mq[ch].push_back(m);
      for (int b = 0; b < nbeats; b++) begin
         beat_t bt;
         for (int w = 0; w < 16; w++) bt.data[w*32 +: 32] = $urandom;
         bt.sop = (b == 0) || (b == bad_sop_beat);
         bt.eop = (b == nbeats - 1);
         bt.empty = bt.eop ? 6'($urandom_range(63)) : 6'd0;
         bq[ch].push_back(bt);
      end
   endtask

   function automatic bit busy();
      busy = (m_phase != 0);
      for (int c = 0; c < NCH; c++) if (bq[c].size() != 0 || mq[c].size() != 0) busy = 1;
   endfunction

   task automatic check_idle_outputs(string tag);
      logic [3:0] mr, pr;
      for (int c = 0; c < NCH; c++) begin
         mr[c] = bus.in_meta_ready[c];
         pr[c] = bus.in_pkt_ready[c];
      end
      check({tag, "_meta_valid"}, bus.out_meta_valid, 0);
      check({tag, "_pkt_valid"}, bus.out_pkt_valid, 0);
      check({tag, "_meta_ready"}, mr, 0);
      check({tag, "_pkt_ready"}, pr, 0);
      check({tag, "_meta_channel"}, bus.out_meta_channel, 0);
      check({tag, "_pkt_channel"}, bus.out_pkt_channel, 0);
      check({tag, "_proto_err"}, bus.proto_err, 0);
   endtask

   // reset lands on a negedge; outputs must drop at once since the reset is asynchronous
   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("reset");
      for (int c = 0; c < NCH; c++) begin
         bq[c].delete();
         mq[c].delete();
      end
      zero_inputs();
      m_phase = 0; m_sel = 0; m_rr = 0; m_first = 0; m_err = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // one clock: drive at negedge, compare 1ns later, then advance model and sources
   task automatic step();
      logic mr, pr, paf, maf;
      logic [3:0] got_mr, got_pr, exp_mr, exp_pr;
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
         drv_mv[c] = (mq[c].size() != 0) && !(gaps && $urandom_range(3) == 0);
         drv_pv[c] = (bq[c].size() != 0) && !(gaps && $urandom_range(3) == 0);
         bus.in_meta_valid[c] = drv_mv[c];
         bus.in_pkt_valid[c] = drv_pv[c];
         bus.in_meta_data[c] = (mq[c].size() != 0) ? mq[c][0] : '0;
         if (bq[c].size() != 0) begin
            bus.in_pkt_data[c] = bq[c][0].data;
            bus.in_pkt_sop[c] = bq[c][0].sop;
            bus.in_pkt_eop[c] = bq[c][0].eop;
            bus.in_pkt_empty[c] = bq[c][0].empty;
         end else begin
            bus.in_pkt_data[c] = '0;
            bus.in_pkt_sop[c] = 1'b0;
            bus.in_pkt_eop[c] = 1'b0;
            bus.in_pkt_empty[c] = '0;
         end
         drv_sop[c] = drv_pv[c] && bus.in_pkt_sop[c];
      end
      mr = (mr_mode == 0) ? 1'b1 : 1'($urandom_range(1));
      pr = (pr_mode == 0) ? 1'b1 : (pr_mode == 1) ? 1'($urandom_range(1)) : 1'(cyc % 2 == 0);
      paf = paf_set || (rand_af && $urandom_range(3) == 0);
      maf = rand_af && $urandom_range(3) == 0;
      bus.out_meta_ready = mr;
      bus.out_pkt_ready = pr;
      bus.out_pkt_almost_full = paf;
      bus.out_meta_almost_full = maf;
      #1;
      exp_mr = '0; exp_pr = '0;
      if (m_phase == 1 && mr) exp_mr[m_sel] = 1'b1;
      if (m_phase == 2 && pr) exp_pr[m_sel] = 1'b1;
      for (int c = 0; c < NCH; c++) begin
         got_mr[c] = bus.in_meta_ready[c];
         got_pr[c] = bus.in_pkt_ready[c];
      end
      check("in_meta_ready", got_mr, exp_mr);
      check("in_pkt_ready", got_pr, exp_pr);
      check("out_meta_valid", bus.out_meta_valid, m_phase == 1 && drv_mv[m_sel]);
      check("out_pkt_valid", bus.out_pkt_valid, m_phase == 2 && drv_pv[m_sel]);
      check("out_meta_channel", bus.out_meta_channel, m_sel);
      check("out_pkt_channel", bus.out_pkt_channel, m_sel);
      check("proto_err", bus.proto_err, m_err);
      if (m_phase == 1 && drv_mv[m_sel] && mr)
         check("out_meta_data", bus.out_meta_data, mq[m_sel][0]);
      if (m_phase == 2 && drv_pv[m_sel] && pr) begin
         check("out_pkt_data", bus.out_pkt_data, bq[m_sel][0].data);
         check("out_pkt_sop", bus.out_pkt_sop, bq[m_sel][0].sop);
         check("out_pkt_eop", bus.out_pkt_eop, bq[m_sel][0].eop);
         check("out_pkt_empty", bus.out_pkt_empty, bq[m_sel][0].empty);
      end
      // model advance
      case (m_phase)
         0: begin
            if (!paf && !maf) begin
               for (int i = 0; i < NCH; i++) begin
                  int ch;
                  ch = (m_rr + i) % NCH;
                  if (drv_mv[ch] && drv_pv[ch] && drv_sop[ch]) begin
                     m_sel = ch;
                     m_rr = (ch + 1) % NCH;
                     m_phase = 1;
                     grants.push_back(ch);
                     gcycs.push_back(cyc);
                     break;
                  end
               end
            end
         end
         1: begin
            if (drv_mv[m_sel] && mr) begin
               m_phase = 2;
               m_first = 1;
               meta_cyc = cyc;
            end
         end
         default: begin
            if (drv_pv[m_sel] && pr) begin
`ifdef CHANNEL_ARBITER_CHECK_EN
               if (bq[m_sel][0].sop != m_first) m_err = 1;
`endif
               m_first = 0;
               beats_out++;
               beat_cycs.push_back(cyc);
               if (bq[m_sel][0].eop) m_phase = 0;
            end
         end
      endcase
      // sources consume on the DUT's own readies
      for (int c = 0; c < NCH; c++) begin
         if (drv_mv[c] && bus.in_meta_ready[c]) void'(mq[c].pop_front());
         if (drv_pv[c] && bus.in_pkt_ready[c]) void'(bq[c].pop_front());
      end
      cyc++;
   endtask

   task automatic drain(int budget);
      int n = 0;
      while (busy() && n < budget) begin
         step();
         n++;
      end
      check("drain_timeout", busy(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t;
      int n;
      int exp_order[5];
      int total;
      zero_inputs();
      apply_reset();

      // single channel 2 packet, sinks always ready
      clear_logs();
      add_pkt(2, 3);
      drain(40);
      check("s1_grant_count", grants.size(), 1);
      if (grants.size() == 1) begin
         check("s1_grant_ch", grants[0], 2);
         check("s1_meta_cycle", meta_cyc, gcycs[0] + 1);
      end
      check("s1_beat_count", beat_cycs.size(), 3);
      for (int i = 0; i < beat_cycs.size(); i++) check("s1_beat_cycle", beat_cycs[i], meta_cyc + 1 + i);
      step();

      // all four eligible from reset: round-robin order
      apply_reset();
      clear_logs();
      add_pkt(0, 1); add_pkt(0, 1); add_pkt(1, 1); add_pkt(2, 1); add_pkt(3, 1);
      drain(80);
      exp_order = '{0, 1, 2, 3, 0};
      check("s2_grant_count", grants.size(), 5);
      for (int i = 0; i < grants.size() && i < 5; i++) check("s2_grant_order", grants[i], exp_order[i]);

      // packet almost-full holds off a grant
      clear_logs();
      paf_set = 1;
      add_pkt(1, 2);
      repeat (6) step();
      check("s3_no_grant", grants.size(), 0);
      paf_set = 0;
      t = cyc;
      drain(40);
      check("s3_grant_count", grants.size(), 1);
      if (grants.size() == 1) begin
         check("s3_grant_ch", grants[0], 1);
         check("s3_grant_cycle", gcycs[0], t);
      end

      // sink ready alternating through a 4-beat packet
      clear_logs();
      pr_mode = 2;
      add_pkt(3, 4);
      drain(60);
      check("s4_beats", beats_out, 4);
      pr_mode = 0;

      // reset in the middle of a 5-beat packet
      clear_logs();
      add_pkt(1, 5);
      n = 0;
      while (beats_out < 1 && n < 40) begin
         step();
         n++;
      end
      check("s5_first_beat", beats_out, 1);
      apply_reset();
      clear_logs();
      add_pkt(1, 1); add_pkt(2, 1);
      drain(40);
      check("s5_grant_count", grants.size(), 2);
      if (grants.size() != 0) check("s5_restart_ch", grants[0], 1);

`ifdef CHANNEL_ARBITER_CHECK_EN
      // stray sop on the second beat
      clear_logs();
      add_pkt(0, 3, 1);
      drain(40);
      check("s6_proto_err_set", bus.proto_err, 1);
      repeat (3) step();
      check("s6_proto_err_held", bus.proto_err, 1);
      apply_reset();
`endif

      // randomized traffic with stalls, gaps and almost-full
      gaps = 1; mr_mode = 1; pr_mode = 1; rand_af = 1;
      for (int r = 0; r < 30; r++) begin
         clear_logs();
         total = 0;
         for (int k = 0; k < 1 + $urandom_range(4); k++) begin
            int nb;
            nb = 1 + $urandom_range(5);
            add_pkt($urandom_range(NCH - 1), nb);
            total += nb;
         end
         drain(800);
         check("rand_beats", beats_out, total);
      end
      gaps = 0; mr_mode = 0; pr_mode = 0; rand_af = 0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/channel_arbiter.md
CHANNEL_ARBITER -- requirements
Module: channel_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 4, meaning the number of input channels (2..4; the channel index is 2 bits).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have per-channel packet inputs in_pkt_data [NUM_CH][511:0], in_pkt_valid [NUM_CH], in_pkt_sop [NUM_CH], in_pkt_eop [NUM_CH] and in_pkt_empty [NUM_CH][5:0], plus output in_pkt_ready [NUM_CH].
REQ-005 The module SHALL have per-channel metadata inputs in_meta_data [NUM_CH] (metadata_t) and in_meta_valid [NUM_CH], plus output in_meta_ready [NUM_CH].
REQ-006 The module SHALL have merged packet outputs out_pkt_data [511:0], out_pkt_valid, out_pkt_sop, out_pkt_eop, out_pkt_empty [5:0] and out_pkt_channel [1:0], plus inputs out_pkt_ready and out_pkt_almost_full.
REQ-007 The module SHALL have merged metadata outputs out_meta_data (metadata_t), out_meta_valid and out_meta_channel [1:0], plus inputs out_meta_ready and out_meta_almost_full.
REQ-008 The module SHALL have output proto_err, 1 bit: sticky protocol-error flag (see Configuration).

Function
REQ-009 The FSM SHALL have exactly three states: IDLE, META and PKT.
REQ-010 A channel SHALL be eligible in IDLE when in_meta_valid=1, in_pkt_valid=1 and in_pkt_sop=1 for that channel.
REQ-011 In IDLE, when at least one channel is eligible and both out_pkt_almost_full=0 and out_meta_almost_full=0, the arbiter SHALL register sel = the first eligible channel searching round-robin from rr_ptr, then go to META; no input handshake occurs in IDLE.
REQ-012 When a grant is issued in IDLE, rr_ptr SHALL be set to (sel+1) mod NUM_CH.
REQ-013 In META, out_meta_valid SHALL equal in_meta_valid[sel], out_meta_data SHALL equal in_meta_data[sel], and in_meta_ready[sel] SHALL equal out_meta_ready; on that handshake the FSM SHALL go to PKT.
REQ-014 In PKT, out_pkt_valid/data/sop/eop/empty SHALL pass through combinationally from channel sel, and in_pkt_ready[sel] SHALL equal out_pkt_ready.
REQ-015 In PKT, a handshake with eop=1 SHALL return the FSM to IDLE; sop and eop set on the same beat SHALL be a complete one-beat packet.
REQ-016 All non-selected in_*_ready SHALL be 0; outside META out_meta_valid SHALL be 0, and outside PKT out_pkt_valid SHALL be 0.
REQ-017 out_pkt_channel and out_meta_channel SHALL both equal the registered sel.
REQ-018 Minimum packet overhead SHALL be 2 cycles (IDLE, then META) before the first packet beat.
REQ-019 Almost-full inputs SHALL be sampled only in IDLE; a packet already in progress SHALL never be interrupted by almost-full.

Reset
REQ-020 On rst_n=0, the FSM SHALL go to IDLE, with sel=0, rr_ptr=0 and proto_err=0.
REQ-021 On rst_n=0, all valid and ready outputs SHALL be 0 and both channel outputs SHALL be 0.
REQ-022 A reset asserted mid-packet SHALL abandon the packet; after release, arbitration SHALL restart from channel 0.

Configuration
REQ-023 With macro CHANNEL_ARBITER_CHECK_EN defined, proto_err SHALL set and hold when, in PKT, a handshaked beat has sop=1 and is not the first beat of the packet.
REQ-024 With CHANNEL_ARBITER_CHECK_EN defined, proto_err SHALL also set and hold when the first handshaked beat in PKT has sop=0.
REQ-025 With CHANNEL_ARBITER_CHECK_EN defined, proto_err SHALL clear only on reset.
REQ-026 Without CHANNEL_ARBITER_CHECK_EN, proto_err SHALL be tied to 0 and no checker logic SHALL be present.

Verification
REQ-027 The bench SHALL cover: ch2 only, meta plus a 3-beat packet, sinks always ready -> out_meta_channel=2 for 1 cycle, then 3 pkt beats with out_pkt_channel=2, sop on beat 1, eop on beat 3; the FSM is back in IDLE the next cycle.
REQ-028 The bench SHALL cover: ch0..ch3 all eligible with 1-beat packets from reset -> grant order 0,1,2,3,0.
REQ-029 The bench SHALL cover: out_pkt_almost_full=1 in IDLE with ch1 eligible -> no grant and all readies 0; deassert -> ch1 granted 1 cycle later.
REQ-030 The bench SHALL cover: out_pkt_ready toggling 1,0,1,0 during a 4-beat ch3 packet -> no beat lost or duplicated, and in_pkt_ready[3] tracks out_pkt_ready.
REQ-031 The bench SHALL cover: rst_n pulsed low during beat 2 of a 5-beat ch1 packet -> all valids 0 immediately and rr_ptr=0.
REQ-032 The bench SHALL cover, with CHANNEL_ARBITER_CHECK_EN defined: second beat of a packet carries sop=1 -> proto_err=1 the next cycle and it stays 1 until reset.
